register_file_sb: RTL and testbench
===================================

Name: register_file_sb

Overview:
- Parametrised successor to the single-port-pair register file, for the pipelined core.
- Provides NUM_READ combinational read ports, one write-back port, and an x0 hard-wired to zero.
- Adds a busy-bit scoreboard: decode allocates a destination, write-back releases it, and read ports report pending operands so decode can stall.
- Sits between decode (read/alloc) and write-back (write/release).

Parameters:
- XLEN, 64, data width of each register.
- NUM_REGS, 32, number of architectural registers; power of two, >= 2.
- NUM_READ, 2, number of read ports, 1..4.
- AW, $clog2(NUM_REGS), register index width; derived, not overridden.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- rs_addr  in  NUM_READ*AW  packed read indices; port i occupies [i*AW +: AW].
- rs_data  out  NUM_READ*XLEN  packed read data, combinational.
- rs_busy  out  NUM_READ  1 = operand i has a pending writer.
- reg_write  in  1  write-back strobe.
- Rd  in  AW  write-back destination index.
- write_data  in  XLEN  write-back data.
- alloc_valid  in  1  decode requests destination allocation.
- alloc_rd  in  AW  destination to mark busy.
- alloc_ready  out  1  allocation will be accepted this cycle.
- flush  in  1  clears all busy bits (pipeline squash).
- busy_count  out  AW+1  number of registers currently busy.

Behaviour:
- Reset (rst=0, asynchronous): all registers = 0, all busy bits = 0, busy_count = 0. rs_data follows the zeroed array; rs_busy = 0; alloc_ready = 1 (busy bits clear).
- Reads: rs_data[i] = regs[rs_addr[i]], zero latency. Index 0 always reads 0 with rs_busy[i] = 0.
- Write: on a rising edge with reg_write=1 and Rd!=0, regs[Rd] <= write_data. Writes to x0 are discarded. Write-back to a non-busy register is legal and still writes.
- Release: a write with Rd!=0 clears busy[Rd] at the same edge.
- alloc_ready = !busy[alloc_rd] || (reg_write && Rd==alloc_rd) || alloc_rd==0.
- Accepted alloc (alloc_valid && alloc_ready && !flush && alloc_rd!=0) sets busy[alloc_rd] at the edge. If alloc_valid && !alloc_ready, nothing changes; decode must hold the request.
- Same register released and allocated in one cycle: data is written and busy ends at 1 (alloc wins).
- flush=1: all busy bits clear at the edge and any alloc that cycle is ignored. A write-back in the same cycle still writes data.
- busy_count: registered, always equals the popcount of the busy bits; maximum NUM_REGS-1. Changes by +1, -1 or 0 per cycle, or drops to 0 on flush.
- Reset asserted mid-operation clears all state immediately; no pending allocations survive.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a read whose index matches Rd while reg_write=1 and Rd!=0 returns write_data in that cycle, and the port's rs_busy is 0 (write-to-read forwarding).
- Undefined: reads return the old array value and the old busy bit until the following cycle.
- Scoreboard update timing is identical in both builds.

Decomposition:
- Package regfile_pkg:
  - XLEN_DEFAULT = 64, NUM_REGS_DEFAULT = 32.
  - ZERO_REG = 0.
  - typedef xlen_t (XLEN-wide data) and reg_idx_t (AW-wide index).
- One sub-module, regfile_scoreboard: holds the busy vector, alloc_ready logic, flush handling and busy_count.
- The data array and read muxing stay in the top module.

Test Plan:
- Reset, then write 64'h123456789ABCDEF0 to x1; next cycle read x1 on port 0 -> 64'h123456789ABCDEF0, rs_busy[0] = 0.
- Alloc x10 -> rs_busy = 1 for a read of x10, busy_count = 1. Write-back 64'hFEDCBA9876543210 to x10 -> next cycle busy 0, data correct, busy_count = 0.
- Write 64'h1111111111111111 to x0 and alloc x0 -> x0 reads 0, busy 0, busy_count unchanged.
- Alloc x5 while busy without write-back -> alloc_ready = 0, busy_count unchanged. Same cycle as write-back to x5 -> alloc_ready = 1, busy stays 1 after the edge.
- Alloc x3, x4, x7, then flush asserted together with alloc x8 -> all busy bits 0, busy_count = 0, x8 not busy.
- Assert rst low mid-cycle with x2 busy and holding 64'hAA -> immediately x2 reads 0, rs_busy = 0, busy_count = 0.
- Bypass build: write 64'h55 to x6 while port 1 reads x6 -> same-cycle rs_data port 1 = 64'h55. Non-bypass build: the old value is returned that cycle.

Source files
------------

// File: rtl/register_file_sb_pkg.sv
// Shared constants and types for the scoreboarded register file.
// Build option: define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
package regfile_pkg;

  localparam int unsigned XLEN_DEFAULT     = 64;
  localparam int unsigned NUM_REGS_DEFAULT = 32;
  localparam int unsigned ZERO_REG         = 0;

  typedef logic [XLEN_DEFAULT-1:0]              xlen_t;
  typedef logic [$clog2(NUM_REGS_DEFAULT)-1:0]  reg_idx_t;

endpackage

// File: rtl/register_file_sb_if.sv
// Decode/write-back bus of the scoreboarded register file.
// master = pipeline side (decode + write-back), slave = register file.
interface register_file_sb_if
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEFAULT,
  parameter int unsigned NUM_REGS = NUM_REGS_DEFAULT,
  parameter int unsigned NUM_READ = 2
);
  localparam int unsigned AW = $clog2(NUM_REGS);

  logic [NUM_READ*AW-1:0]   rs_addr;
  logic [NUM_READ*XLEN-1:0] rs_data;
  logic [NUM_READ-1:0]      rs_busy;
  logic                     reg_write;
  logic [AW-1:0]            Rd;
  logic [XLEN-1:0]          write_data;
  logic                     alloc_valid;
  logic [AW-1:0]            alloc_rd;
  logic                     alloc_ready;
  logic                     flush;
  logic [AW:0]              busy_count;

  modport master (
    output rs_addr, reg_write, Rd, write_data, alloc_valid, alloc_rd, flush,
    input  rs_data, rs_busy, alloc_ready, busy_count
  );

  modport slave (
    input  rs_addr, reg_write, Rd, write_data, alloc_valid, alloc_rd, flush,
    output rs_data, rs_busy, alloc_ready, busy_count
  );

endinterface

// File: rtl/register_file_sb_scoreboard.sv
// Busy-bit scoreboard: decode allocates destinations, write-back releases them,
// flush squashes all pending writers. busy_count tracks the popcount as a register.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        reg_write,
  input  logic [$clog2(NUM_REGS)-1:0] rd,
  input  logic                        alloc_valid,
  input  logic [$clog2(NUM_REGS)-1:0] alloc_rd,
  input  logic                        flush,
  output logic [NUM_REGS-1:0]         busy,
  output logic                        alloc_ready,
  output logic [$clog2(NUM_REGS):0]   busy_count
);
  localparam int unsigned AW = $clog2(NUM_REGS);

  logic [NUM_REGS-1:0] busy_n;
  logic [AW:0]         count_n;
  logic                release_hit;
  logic                alloc_take;

  assign release_hit = reg_write && (rd != AW'(ZERO_REG));
  assign alloc_ready = !busy[alloc_rd] || (reg_write && (rd == alloc_rd)) ||
                       (alloc_rd == AW'(ZERO_REG));
  assign alloc_take  = alloc_valid && alloc_ready && !flush &&
                       (alloc_rd != AW'(ZERO_REG));

  // Release is applied before allocation so a same-cycle release+alloc ends busy.
  always_comb begin
    busy_n = busy;
    if (release_hit)
      busy_n[rd] = 1'b0;
    if (flush)
      busy_n = '0;
    else if (alloc_take)
      busy_n[alloc_rd] = 1'b1;
    busy_n[0] = 1'b0;
  end

  always_comb begin
    count_n = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      if (busy_n[i])
        count_n = count_n + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_n;
      busy_count <= count_n;
    end
  end

endmodule

// File: rtl/register_file_sb.sv
// Parametrised register file with NUM_READ combinational read ports, one write-back
// port, x0 hard-wired to zero and a busy-bit scoreboard. Option: REGFILE_BYPASS_EN.
module register_file_sb
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEFAULT,
  parameter int unsigned NUM_REGS = NUM_REGS_DEFAULT,
  parameter int unsigned NUM_READ = 2
) (
  input logic               clk,
  input logic               rst,
  register_file_sb_if.slave bus
);
  localparam int unsigned AW = $clog2(NUM_REGS);

  logic [XLEN-1:0]     regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic                wr_en;

  assign wr_en = bus.reg_write && (bus.Rd != AW'(ZERO_REG));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (wr_en) begin
      regs[bus.Rd] <= bus.write_data;
    end
  end

  regfile_scoreboard #(
    .NUM_REGS(NUM_REGS)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .reg_write  (bus.reg_write),
    .rd         (bus.Rd),
    .alloc_valid(bus.alloc_valid),
    .alloc_rd   (bus.alloc_rd),
    .flush      (bus.flush),
    .busy       (busy),
    .alloc_ready(bus.alloc_ready),
    .busy_count (bus.busy_count)
  );

  // x0 is never written and its busy bit is never set, so a plain index reads zero.
  always_comb begin
    bus.rs_data = '0;
    bus.rs_busy = '0;
    for (int unsigned i = 0; i < NUM_READ; i++) begin
      bus.rs_data[i*XLEN +: XLEN] = regs[bus.rs_addr[i*AW +: AW]];
      bus.rs_busy[i]              = busy[bus.rs_addr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (bus.rs_addr[i*AW +: AW] == bus.Rd)) begin
        bus.rs_data[i*XLEN +: XLEN] = bus.write_data;
        bus.rs_busy[i]              = 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_register_file_sb.sv
// Self-checking bench for register_file_sb: directed scenarios plus randomized
// traffic compared against an array-based model of the register file and scoreboard.
module tb_register_file_sb;

  localparam int unsigned XLEN = 64;
  localparam int unsigned NREG = 32;
  localparam int unsigned NRD  = 2;
  localparam int unsigned AW   = 5;

  logic clk;
  logic rst;

  register_file_sb_if #(.XLEN(XLEN), .NUM_REGS(NREG), .NUM_READ(NRD)) bus ();

  register_file_sb #(.XLEN(XLEN), .NUM_REGS(NREG), .NUM_READ(NRD)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [63:0] m_regs [NREG];
  bit          m_busy [NREG];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < NREG; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic logic [63:0] m_read(input int a);
`ifdef REGFILE_BYPASS_EN
    if (bus.reg_write && bus.Rd != 0 && int'(bus.Rd) == a) return bus.write_data;
`endif
    return (a == 0) ? 64'd0 : m_regs[a];
  endfunction

  function automatic bit m_rbusy(input int a);
`ifdef REGFILE_BYPASS_EN
    if (bus.reg_write && bus.Rd != 0 && int'(bus.Rd) == a) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  function automatic bit m_ready();
    int a = int'(bus.alloc_rd);
    return (a == 0) || !m_busy[a] || (bus.reg_write && bus.Rd == bus.alloc_rd);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NREG; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic idle();
    bus.rs_addr     = '0;
    bus.reg_write   = 1'b0;
    bus.Rd          = '0;
    bus.write_data  = '0;
    bus.alloc_valid = 1'b0;
    bus.alloc_rd    = '0;
    bus.flush       = 1'b0;
  endtask

  task automatic set_reads(input int a0, input int a1);
    bus.rs_addr = {AW'(a1), AW'(a0)};
  endtask

  // Inputs are driven at a falling edge; outputs checked 1ns later, then one clock.
  task automatic cycle();
    bit rdy;
    int wr, ar;
    #1;
    for (int p = 0; p < NRD; p++) begin
      int a = int'(bus.rs_addr[p*AW +: AW]);
      check($sformatf("rs_data%0d[x%0d]", p, a), bus.rs_data[p*XLEN +: XLEN], m_read(a));
      check($sformatf("rs_busy%0d[x%0d]", p, a), 64'(bus.rs_busy[p]), 64'(m_rbusy(a)));
    end
    rdy = m_ready();
    check("alloc_ready", 64'(bus.alloc_ready), 64'(rdy));
    check("busy_count", 64'(bus.busy_count), 64'(m_count()));
    @(posedge clk);
    wr = int'(bus.Rd);
    ar = int'(bus.alloc_rd);
    if (bus.reg_write && wr != 0) begin
      m_regs[wr] = bus.write_data;
      m_busy[wr] = 1'b0;
    end
    if (bus.flush) begin
      for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
    end else if (bus.alloc_valid && rdy && ar != 0) begin
      m_busy[ar] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic do_write(input int r, input logic [63:0] d);
    idle();
    bus.reg_write = 1'b1; bus.Rd = AW'(r); bus.write_data = d;
    cycle();
  endtask

  task automatic do_alloc(input int r);
    idle();
    bus.alloc_valid = 1'b1; bus.alloc_rd = AW'(r);
    cycle();
  endtask

  initial begin
    rst = 1'b0;
    idle();
    m_reset();
    repeat (2) @(negedge clk);

    // Reset state
    set_reads(1, 31);
    #1;
    check("reset_data0", bus.rs_data[63:0], 64'd0);
    check("reset_busy", 64'(bus.rs_busy), 64'd0);
    check("reset_ready", 64'(bus.alloc_ready), 64'd1);
    check("reset_count", 64'(bus.busy_count), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Write x1, read back
    do_write(1, 64'h123456789ABCDEF0);
    idle(); set_reads(1, 0);
    #1;
    check("x1_data", bus.rs_data[63:0], 64'h123456789ABCDEF0);
    check("x1_busy", 64'(bus.rs_busy[0]), 64'd0);
    cycle();

    // Alloc x10 then write back
    do_alloc(10);
    idle(); set_reads(10, 0);
    #1;
    check("x10_busy", 64'(bus.rs_busy[0]), 64'd1);
    check("x10_count", 64'(bus.busy_count), 64'd1);
    cycle();
    do_write(10, 64'hFEDCBA9876543210);
    idle(); set_reads(10, 0);
    #1;
    check("x10_rel_busy", 64'(bus.rs_busy[0]), 64'd0);
    check("x10_rel_data", bus.rs_data[63:0], 64'hFEDCBA9876543210);
    check("x10_rel_count", 64'(bus.busy_count), 64'd0);
    cycle();

    // x0 is immune to writes and allocs
    idle();
    bus.reg_write = 1'b1; bus.Rd = '0; bus.write_data = 64'h1111111111111111;
    bus.alloc_valid = 1'b1; bus.alloc_rd = '0;
    cycle();
    idle(); set_reads(0, 0);
    #1;
    check("x0_data", bus.rs_data[63:0], 64'd0);
    check("x0_busy", 64'(bus.rs_busy[0]), 64'd0);
    check("x0_count", 64'(bus.busy_count), 64'd0);
    cycle();

    // Re-alloc of busy x5 stalls; with same-cycle write-back it is accepted
    do_alloc(5);
    idle(); bus.alloc_valid = 1'b1; bus.alloc_rd = AW'(5);
    #1;
    check("x5_stall_ready", 64'(bus.alloc_ready), 64'd0);
    cycle();
    check("x5_stall_count", 64'(bus.busy_count), 64'd1);
    idle(); bus.alloc_valid = 1'b1; bus.alloc_rd = AW'(5);
    bus.reg_write = 1'b1; bus.Rd = AW'(5); bus.write_data = 64'h5A5A;
    #1;
    check("x5_wb_ready", 64'(bus.alloc_ready), 64'd1);
    cycle();
    idle(); set_reads(5, 5);
    #1;
    check("x5_still_busy", 64'(bus.rs_busy[0]), 64'd1);
    check("x5_data", bus.rs_data[63:0], 64'h5A5A);
    cycle();

    // Flush wins over a same-cycle alloc
    do_alloc(3); do_alloc(4); do_alloc(7);
    idle(); bus.flush = 1'b1; bus.alloc_valid = 1'b1; bus.alloc_rd = AW'(8);
    cycle();
    idle(); set_reads(8, 3);
    #1;
    check("flush_count", 64'(bus.busy_count), 64'd0);
    check("flush_busy", 64'(bus.rs_busy), 64'd0);
    cycle();

    // Same-cycle write/read of x6: forwarded only in the bypass build
    do_write(6, 64'h77);
    idle(); set_reads(0, 6);
    bus.reg_write = 1'b1; bus.Rd = AW'(6); bus.write_data = 64'h55;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("x6_bypass", bus.rs_data[127:64], 64'h55);
`else
    check("x6_old", bus.rs_data[127:64], 64'h77);
`endif
    cycle();

    // Randomized traffic, biased to a few registers for collisions
    for (int n = 0; n < 600; n++) begin
      idle();
      set_reads(int'($urandom_range(0, 7)), int'($urandom_range(0, 31)));
      bus.reg_write   = ($urandom_range(0, 1) == 1);
      bus.Rd          = AW'($urandom_range(0, 7));
      bus.write_data  = {$urandom, $urandom};
      bus.alloc_valid = ($urandom_range(0, 2) != 0);
      bus.alloc_rd    = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31))
                                                    : AW'($urandom_range(0, 7));
      bus.flush       = ($urandom_range(0, 15) == 0);
      cycle();
    end

    // Asynchronous reset mid-cycle with x2 busy and holding 0xAA
    do_write(2, 64'hAA);
    do_alloc(2);
    idle(); set_reads(2, 2);
    #2;
    rst = 1'b0;
    m_reset();
    #1;
    check("arst_data", bus.rs_data[63:0], 64'd0);
    check("arst_busy", 64'(bus.rs_busy), 64'd0);
    check("arst_count", 64'(bus.busy_count), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
